// File: rtl/hopfield_assoc_mem.sv
// Hopfield associative memory: Hebbian learning into an N x N saturating weight
// array and sequential (asynchronous-update) recall of the nearest attractor.
module hopfield_assoc_mem #(
    parameter int unsigned N          = 25,
    parameter int unsigned WW         = 4,
    parameter int unsigned MAX_SWEEPS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_req,
    input  logic                             learn_valid,
    input  logic [N-1:0]                     learn_pat,
    input  logic                             recall_valid,
    input  logic [N-1:0]                     recall_pat,
    output logic                             ready,
    output logic                             busy,
    output logic                             done,
    output logic                             converged,
    output logic [$clog2(MAX_SWEEPS+1)-1:0]  sweeps,
    output logic [N-1:0]                     result,
    input  logic [$clog2(N*N)-1:0]           w_raddr,
    output logic [WW-1:0]                    w_rdata
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned KW = $clog2(N);
    localparam int unsigned SW = $clog2(MAX_SWEEPS + 1);
    localparam int unsigned AW = $clog2(N * (2 ** (WW - 1))) + 2;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NN - 1);
    localparam logic [WW-1:0] W_MAX  = {1'b0, {(WW-1){1'b1}}};
    localparam logic [WW-1:0] W_MIN  = {1'b1, {(WW-1){1'b0}}};

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_LEARN  = 3'd2;
    localparam logic [2:0] S_RECALL = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [KW-1:0] k, k_d;
    logic [KW-1:0] m, m_d;
    logic          upd, upd_d;
    logic          flip, flip_d;
    logic [AW-1:0] acc, acc_d;
    logic [N-1:0]  pat, pat_d;
    logic          ready_d, busy_d, done_d, conv_d;
    logic [SW-1:0] sweeps_d, sweeps_inc;
    logic [N-1:0]  result_d;

    logic [WW-1:0] w_mem [NN];
    logic          w_we;
    logic [IW-1:0] w_waddr;
    logic [WW-1:0] w_wdata;

    logic [IW-1:0] km_addr;
    logic [WW-1:0] wcur;
    logic [WW:0]   wsum;
    logic [WW-1:0] wsat;
    logic [AW-1:0] wext, term;
    logic          acc_pos, acc_neg;
    logic          bit_new, flip_now;

    // Weight w[k][m] lives at k*N+m; shared by learn and recall.
    assign km_addr = IW'(32'(k) * N + 32'(m));
    assign wcur    = w_mem[km_addr];

    // Hebbian step +/-1 in one extra bit, then clamp to the signed weight range.
    always_comb begin
        wsum = {wcur[WW-1], wcur} + ((pat[k] == pat[m]) ? {{WW{1'b0}}, 1'b1} : {(WW+1){1'b1}});
        if (wsum[WW] != wsum[WW-1]) begin
            wsat = wsum[WW] ? W_MIN : W_MAX;
        end else begin
            wsat = wsum[WW-1:0];
        end
    end

    assign wext    = {{(AW-WW){wcur[WW-1]}}, wcur};
    assign term    = result[m] ? wext : (AW'(0) - wext);
    assign acc_pos = !acc[AW-1] && (acc != '0);
    assign acc_neg = acc[AW-1];
    assign sweeps_inc = sweeps + SW'(1);

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        k_d      = k;
        m_d      = m;
        upd_d    = upd;
        flip_d   = flip;
        acc_d    = acc;
        pat_d    = pat;
        sweeps_d = sweeps;
        conv_d   = converged;
        result_d = result;
        w_we     = 1'b0;
        w_waddr  = km_addr;
        w_wdata  = '0;
        bit_new  = 1'b0;
        flip_now = 1'b0;

        case (state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = idx;
                if (idx == I_LAST) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx + IW'(1);
                end
            end

            S_IDLE: begin
                if (clear_req) begin
                    idx_d   = '0;
                    state_d = S_CLEAR;
                end else if (learn_valid) begin
                    pat_d   = learn_pat;
                    k_d     = '0;
                    m_d     = '0;
                    state_d = S_LEARN;
                end else if (recall_valid) begin
                    result_d = recall_pat;
                    sweeps_d = '0;
                    conv_d   = 1'b0;
                    k_d      = '0;
                    m_d      = '0;
                    upd_d    = 1'b0;
                    flip_d   = 1'b0;
                    acc_d    = '0;
                    state_d  = S_RECALL;
                end
            end

            S_LEARN: begin
                w_we    = 1'b1;
                w_wdata = (k == m) ? '0 : wsat;
                if (m == K_LAST) begin
                    m_d = '0;
                    if (k == K_LAST) begin
                        k_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        k_d = k + KW'(1);
                    end
                end else begin
                    m_d = m + KW'(1);
                end
            end

            S_RECALL: begin
                if (!upd) begin
                    acc_d = acc + term;
                    if (m == K_LAST) begin
                        m_d   = '0;
                        upd_d = 1'b1;
                    end else begin
                        m_d = m + KW'(1);
                    end
                end else begin
                    // Zero field holds the neuron; later neurons see this update immediately.
                    bit_new      = acc_pos ? 1'b1 : (acc_neg ? 1'b0 : result[k]);
                    result_d[k]  = bit_new;
                    flip_now     = flip || (bit_new != result[k]);
                    flip_d       = flip_now;
                    acc_d        = '0;
                    upd_d        = 1'b0;
                    if (k == K_LAST) begin
                        k_d      = '0;
                        sweeps_d = sweeps_inc;
                        if (!flip_now) begin
                            conv_d  = 1'b1;
                            state_d = S_DONE;
                        end else if (32'(sweeps_inc) == MAX_SWEEPS) begin
                            conv_d  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            flip_d = 1'b0;
                        end
                    end else begin
                        k_d = k + KW'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                idx_d   = '0;
                state_d = S_CLEAR;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_CLEAR) || (state_d == S_LEARN) || (state_d == S_RECALL);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_CLEAR;
            idx       <= '0;
            k         <= '0;
            m         <= '0;
            upd       <= 1'b0;
            flip      <= 1'b0;
            acc       <= '0;
            pat       <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            converged <= 1'b0;
            sweeps    <= '0;
            result    <= '0;
            w_rdata   <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            k         <= k_d;
            m         <= m_d;
            upd       <= upd_d;
            flip      <= flip_d;
            acc       <= acc_d;
            pat       <= pat_d;
            ready     <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
            converged <= conv_d;
            sweeps    <= sweeps_d;
            result    <= result_d;
            w_rdata   <= (32'(w_raddr) < NN) ? w_mem[w_raddr] : '0;
        end
    end

    // Weight storage is deliberately not reset; CLEAR rewrites every entry.
    always_ff @(posedge clk) begin
        if (w_we) begin
            w_mem[w_waddr] <= w_wdata;
        end
    end

endmodule
